// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: walks fetch/decode/execute/load/store phases
// and drives the datapath enables, address/writeback mux selects and BRAM write.
module cpu_sequencer #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [15:0]      instruction,
    output logic             ir_load,
    output logic             pc_enable,
    output logic             reg_we,
    output logic             ls_cntl,
    output logic             wb_mem_sel,
    output logic             mem_we,
    output logic             busy,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = 3;
    localparam logic [WAIT_W-1:0] LAT = WAIT_W'(MEM_LAT);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_FWAIT     = 4'd2,
        S_DECODE    = 4'd3,
        S_EXEC      = 4'd4,
        S_LOAD_ADDR = 4'd5,
        S_LOAD_WAIT = 4'd6,
        S_LOAD_WB   = 4'd7,
        S_STORE     = 4'd8,
        S_HALT      = 4'd9
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              retire_c;

    logic ir_load_d, pc_enable_d, reg_we_d, ls_cntl_d;
    logic wb_mem_sel_d, mem_we_d, busy_d, halted_d;

    assign state    = state_q;
    assign retire_c = (state_q == S_EXEC) || (state_q == S_LOAD_WB) || (state_q == S_STORE);

    // Next state and BRAM wait counter
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                wait_d  = LAT;
                state_d = S_FWAIT;
            end
            S_FWAIT: begin
                wait_d = (wait_q != '0) ? wait_q - WAIT_W'(1) : '0;
                if (wait_q <= WAIT_W'(1)) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Classify the live BRAM word; IR captures it on this same edge
                if (instruction == 16'h0000)
                    state_d = S_HALT;
                else if (instruction[15:12] == 4'b0100 && instruction[7:4] == 4'b0000)
                    state_d = S_LOAD_ADDR;
                else if (instruction[15:12] == 4'b0100 && instruction[7:4] == 4'b0100)
                    state_d = S_STORE;
                else
                    state_d = S_EXEC;
            end
            S_LOAD_ADDR: begin
                wait_d  = LAT;
                state_d = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                wait_d = (wait_q != '0) ? wait_q - WAIT_W'(1) : '0;
                if (wait_q <= WAIT_W'(1)) state_d = S_LOAD_WB;
            end
            S_EXEC, S_LOAD_WB, S_STORE: begin
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore decode of the upcoming state so the outputs register alongside it
    always_comb begin
        ir_load_d    = 1'b0;
        pc_enable_d  = 1'b0;
        reg_we_d     = 1'b0;
        ls_cntl_d    = 1'b0;
        wb_mem_sel_d = 1'b0;
        mem_we_d     = 1'b0;
        busy_d       = 1'b0;
        halted_d     = 1'b0;
        case (state_d)
            S_FETCH, S_FWAIT: begin
                busy_d = 1'b1;
            end
            S_DECODE: begin
                busy_d    = 1'b1;
                ir_load_d = 1'b1;
            end
            S_EXEC: begin
                busy_d      = 1'b1;
                reg_we_d    = 1'b1;
                pc_enable_d = 1'b1;
            end
            S_LOAD_ADDR, S_LOAD_WAIT: begin
                busy_d    = 1'b1;
                ls_cntl_d = 1'b1;
            end
            S_LOAD_WB: begin
                busy_d       = 1'b1;
                ls_cntl_d    = 1'b1;
                wb_mem_sel_d = 1'b1;
                reg_we_d     = 1'b1;
                pc_enable_d  = 1'b1;
            end
            S_STORE: begin
                busy_d      = 1'b1;
                ls_cntl_d   = 1'b1;
                mem_we_d    = 1'b1;
                pc_enable_d = 1'b1;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            retired    <= '0;
            ir_load    <= 1'b0;
            pc_enable  <= 1'b0;
            reg_we     <= 1'b0;
            ls_cntl    <= 1'b0;
            wb_mem_sel <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ir_load    <= ir_load_d;
            pc_enable  <= pc_enable_d;
            reg_we     <= reg_we_d;
            ls_cntl    <= ls_cntl_d;
            wb_mem_sel <= wb_mem_sel_d;
            mem_we     <= mem_we_d;
            busy       <= busy_d;
            halted     <= halted_d;
            // Retired count saturates rather than wrapping
            if (retire_c && (retired != {CNT_W{1'b1}}))
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two instances (MEM_LAT=1/CNT_W=16 and MEM_LAT=3/CNT_W=4)
// checked cycle by cycle against a per-instruction phase-list model.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, run0, rst1, run1;
    logic [15:0] ins0, ins1;
    logic        ir_load0, pc_enable0, reg_we0, ls_cntl0, wb_mem_sel0, mem_we0, busy0, halted0;
    logic        ir_load1, pc_enable1, reg_we1, ls_cntl1, wb_mem_sel1, mem_we1, busy1, halted1;
    logic [3:0]  state0, state1;
    logic [15:0] retired0;
    logic [3:0]  retired1;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ret[2];

    cpu_sequencer #(.MEM_LAT(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst0), .run(run0), .instruction(ins0),
        .ir_load(ir_load0), .pc_enable(pc_enable0), .reg_we(reg_we0), .ls_cntl(ls_cntl0),
        .wb_mem_sel(wb_mem_sel0), .mem_we(mem_we0), .busy(busy0), .halted(halted0),
        .state(state0), .retired(retired0)
    );

    cpu_sequencer #(.MEM_LAT(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst1), .run(run1), .instruction(ins1),
        .ir_load(ir_load1), .pc_enable(pc_enable1), .reg_we(reg_we1), .ls_cntl(ls_cntl1),
        .wb_mem_sel(wb_mem_sel1), .mem_we(mem_we1), .busy(busy1), .halted(halted1),
        .state(state1), .retired(retired1)
    );

    function automatic logic [3:0] get_state(int d);
        return (d == 0) ? state0 : state1;
    endfunction

    // {ir_load, pc_enable, reg_we, ls_cntl, wb_mem_sel, mem_we, busy, halted}
    function automatic logic [7:0] get_flags(int d);
        if (d == 0)
            return {ir_load0, pc_enable0, reg_we0, ls_cntl0, wb_mem_sel0, mem_we0, busy0, halted0};
        return {ir_load1, pc_enable1, reg_we1, ls_cntl1, wb_mem_sel1, mem_we1, busy1, halted1};
    endfunction

    function automatic int get_ret(int d);
        return (d == 0) ? int'(retired0) : int'(retired1);
    endfunction

    function automatic int ret_max(int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    function automatic int sat_inc(int v, int d);
        return (v >= ret_max(d)) ? v : v + 1;
    endfunction

    task automatic set_run(input int d, input logic v);
        if (d == 0) run0 = v; else run1 = v;
    endtask

    task automatic set_ins(input int d, input logic [15:0] v);
        if (d == 0) ins0 = v; else ins1 = v;
    endtask

    // Output set required in each phase, straight from the phase descriptions
    function automatic logic [7:0] exp_flags(int s);
        case (s)
            1, 2:    return 8'b0000_0010;
            3:       return 8'b1000_0010;
            4:       return 8'b0110_0010;
            5, 6:    return 8'b0001_0010;
            7:       return 8'b0111_1010;
            8:       return 8'b0101_0110;
            9:       return 8'b0000_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    // 0 = halt, 1 = load, 2 = store, 3 = ALU/other
    function automatic int cls(logic [15:0] i);
        if (i == 16'h0000) return 0;
        if (i[15:12] == 4'h4 && i[7:4] == 4'h0) return 1;
        if (i[15:12] == 4'h4 && i[7:4] == 4'h4) return 2;
        return 3;
    endfunction

    // Precondition: DUT sampled in FETCH. Checks every phase of one instruction.
    task automatic exec_instr(input int d, input logic [15:0] ins, input bit run_after,
                              input int drop_at);
        int lat;
        int c;
        int last;
        int seq[$];
        lat = (d == 0) ? 1 : 3;
        c = cls(ins);
        set_ins(d, ins);
        seq.push_back(1);
        repeat (lat) seq.push_back(2);
        seq.push_back(3);
        case (c)
            0: seq.push_back(9);
            1: begin
                seq.push_back(5);
                repeat (lat) seq.push_back(6);
                seq.push_back(7);
            end
            2: seq.push_back(8);
            default: seq.push_back(4);
        endcase
        last = seq.size() - 1;
        if (drop_at < 0 || drop_at > last) drop_at = last;
        for (int i = 0; i <= last; i++) begin
            n_cmp++;
            if (get_state(d) !== 4'(seq[i])) begin
                n_err++;
                $display("FAIL phase_state d%0d ins=%h step%0d: got %0d want %0d",
                         d, ins, i, get_state(d), seq[i]);
            end
            n_cmp++;
            if (get_flags(d) !== exp_flags(seq[i])) begin
                n_err++;
                $display("FAIL phase_outputs d%0d ins=%h step%0d: got %b want %b",
                         d, ins, i, get_flags(d), exp_flags(seq[i]));
            end
            if (i == drop_at) set_run(d, run_after);
            if (c == 0 && i == last) break;
            @(negedge clk);
        end
        if (c != 0) begin
            exp_ret[d] = sat_inc(exp_ret[d], d);
            n_cmp++;
            if (get_state(d) !== (run_after ? 4'd1 : 4'd0)) begin
                n_err++;
                $display("FAIL after_instr d%0d ins=%h: got state %0d want %0d",
                         d, ins, get_state(d), run_after ? 1 : 0);
            end
            n_cmp++;
            if (get_ret(d) != exp_ret[d]) begin
                n_err++;
                $display("FAIL retired d%0d ins=%h: got %0d want %0d",
                         d, ins, get_ret(d), exp_ret[d]);
            end
        end
    endtask

    // Precondition: DUT in IDLE. Raises run and checks the step into FETCH.
    task automatic start(input int d);
        set_run(d, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (get_state(d) !== 4'd1) begin
            n_err++;
            $display("FAIL start d%0d: got state %0d want 1", d, get_state(d));
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b0; rst1 = 1'b0;
        run0 = 1'b0; run1 = 1'b0;
        ins0 = 16'h0; ins1 = 16'h0;
        exp_ret[0] = 0; exp_ret[1] = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (get_state(d) !== 4'd0 || get_flags(d) !== 8'h00 || get_ret(d) != 0) begin
                n_err++;
                $display("FAIL reset d%0d: got state %0d flags %b retired %0d want 0/0/0",
                         d, get_state(d), get_flags(d), get_ret(d));
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (get_state(d) !== 4'd0 || get_flags(d) !== 8'h00) begin
                    n_err++;
                    $display("FAIL idle_hold d%0d: got state %0d flags %b want 0",
                             d, get_state(d), get_flags(d));
                end
            end
        end
    endtask

    task automatic test_alu();
        set_ins(0, 16'h0531);
        start(0);
        exec_instr(0, 16'h0531, 1'b1, -1);
    endtask

    task automatic test_load();
        exec_instr(0, 16'h4203, 1'b1, -1);
    endtask

    task automatic test_store();
        exec_instr(0, 16'h4743, 1'b1, -1);
    endtask

    task automatic test_random();
        logic [15:0] ins;
        bit keep;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0:       ins = {4'h4, 4'($urandom), 4'h0, 4'($urandom)};
                1:       ins = {4'h4, 4'($urandom), 4'h4, 4'($urandom)};
                default: ins = 16'($urandom);
            endcase
            if (ins == 16'h0000) ins = 16'h0001;
            keep = ($urandom_range(0, 3) != 0);
            exec_instr(0, ins, keep, -1);
            if (!keep) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    n_cmp++;
                    if (get_state(0) !== 4'd0) begin
                        n_err++;
                        $display("FAIL rand_idle: got state %0d want 0", get_state(0));
                    end
                end
                start(0);
            end
        end
    endtask

    task automatic test_run_drop_reset();
        // Drop run during LOAD_WAIT (phase index 4 at MEM_LAT=1)
        exec_instr(0, 16'h4203, 1'b0, 4);
        set_ins(0, 16'h0531);
        start(0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (get_state(0) !== 4'd4) begin
            n_err++;
            $display("FAIL pre_abort: got state %0d want 4", get_state(0));
        end
        #2 rst0 = 1'b0;
        #1;
        exp_ret[0] = 0;
        n_cmp++;
        if (get_state(0) !== 4'd0 || get_flags(0) !== 8'h00 || get_ret(0) != 0) begin
            n_err++;
            $display("FAIL async_abort: got state %0d flags %b retired %0d want 0/0/0",
                     get_state(0), get_flags(0), get_ret(0));
        end
        run0 = 1'b0;
        @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (get_state(0) !== 4'd0 || get_ret(0) != 0) begin
            n_err++;
            $display("FAIL post_abort: got state %0d retired %0d want 0/0",
                     get_state(0), get_ret(0));
        end
    endtask

    task automatic test_halt();
        set_ins(0, 16'h0000);
        start(0);
        exec_instr(0, 16'h0000, 1'b1, -1);
        for (int k = 0; k < 4; k++) begin
            run0 = k[0];
            @(negedge clk);
            n_cmp++;
            if (get_state(0) !== 4'd9 || get_flags(0) !== 8'b0000_0001) begin
                n_err++;
                $display("FAIL halt_hold: got state %0d flags %b want 9 00000001",
                         get_state(0), get_flags(0));
            end
        end
        #2 rst0 = 1'b0;
        #1;
        exp_ret[0] = 0;
        n_cmp++;
        if (get_state(0) !== 4'd0 || get_ret(0) != 0 || get_flags(0) !== 8'h00) begin
            n_err++;
            $display("FAIL halt_reset: got state %0d retired %0d flags %b want 0",
                     get_state(0), get_ret(0), get_flags(0));
        end
        run0 = 1'b0;
        @(negedge clk);
        rst0 = 1'b1;
    endtask

    task automatic test_mem_lat3();
        int cycles;
        set_ins(1, 16'h4a05);
        start(1);
        exec_instr(1, 16'h4a05, 1'b1, -1);
        // Independent clock count for a second load, FETCH to next FETCH
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (get_state(1) !== 4'd1 && cycles < 50);
        exp_ret[1] = sat_inc(exp_ret[1], 1);
        n_cmp++;
        if (cycles != 10) begin
            n_err++;
            $display("FAIL lat3_load_clocks: got %0d want 10", cycles);
        end
        n_cmp++;
        if (get_ret(1) != exp_ret[1]) begin
            n_err++;
            $display("FAIL lat3_retired: got %0d want %0d", get_ret(1), exp_ret[1]);
        end
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 18; n++)
            exec_instr(1, {4'h1, 12'($urandom)}, 1'b1, -1);
        n_cmp++;
        if (get_ret(1) != 15) begin
            n_err++;
            $display("FAIL retired_saturate: got %0d want 15", get_ret(1));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_random();
        test_run_drop_reset();
        test_halt();
        test_mem_lat3();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
